// File: rtl/buffer_ram_pingpong.sv
// Ping-pong frame store: the capturer fills the back bank while the VGA reads the front bank.
// Banks swap only at a VGA frame start once a completed frame is pending; reset clears both banks.
module buffer_ram_pingpong #(
    parameter int              AW       = 15,
    parameter int              DW       = 12,
    parameter int              IMA_SIZE = 19200,
    parameter logic [DW-1:0]   BG_COLOR = 12'h000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          frame_done,
    input  logic          rd_frame_start,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          front_bank,
    output logic          swap_pending,
    output logic          busy,
    output logic [7:0]    drop_cnt
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMA_SIZE - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] clrAddr_q, clrAddr_d;
    logic          frontBank_q, frontBank_d;
    logic          swapPending_q, swapPending_d;
    logic [7:0]    dropCnt_q, dropCnt_d;
    logic [DW-1:0] rdData_q;

    logic [DW-1:0] bank0 [0:(1<<AW)-1];
    logic [DW-1:0] bank1 [0:(1<<AW)-1];

    logic clearWr;
    logic runWr;

    assign clearWr = (state_q == CLEAR) && !reset;
    assign runWr   = (state_q == RUN) && !reset && wr_en && (wr_addr <= LAST_ADDR);

    always_comb begin
        state_d       = state_q;
        clrAddr_d     = clrAddr_q;
        frontBank_d   = frontBank_q;
        swapPending_d = swapPending_q;
        dropCnt_d     = dropCnt_q;
        case (state_q)
            CLEAR: begin
                clrAddr_d = clrAddr_q + 1'b1;
                if (clrAddr_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A swap consumes the pending frame; a simultaneous frame_done re-arms it.
                if (rd_frame_start && swapPending_q) begin
                    frontBank_d   = ~frontBank_q;
                    swapPending_d = frame_done;
                end else if (frame_done) begin
                    if (swapPending_q && (dropCnt_q != 8'hFF)) begin
                        dropCnt_d = dropCnt_q + 8'd1;
                    end
                    swapPending_d = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CLEAR;
            clrAddr_q     <= '0;
            frontBank_q   <= 1'b0;
            swapPending_q <= 1'b0;
            dropCnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            clrAddr_q     <= clrAddr_d;
            frontBank_q   <= frontBank_d;
            swapPending_q <= swapPending_d;
            dropCnt_q     <= dropCnt_d;
        end
    end

    // Storage has no reset; the clear sequencer initialises it instead.
    always_ff @(posedge clk) begin
        if (clearWr) begin
            bank0[clrAddr_q] <= BG_COLOR;
            bank1[clrAddr_q] <= BG_COLOR;
        end else if (runWr) begin
            if (frontBank_q) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdData_q <= '0;
        end else if (state_q == CLEAR || rd_addr > LAST_ADDR) begin
            rdData_q <= BG_COLOR;
        end else if (frontBank_q) begin
            rdData_q <= bank1[rd_addr];
        end else begin
            rdData_q <= bank0[rd_addr];
        end
    end

    assign rd_data      = rdData_q;
    assign front_bank   = frontBank_q;
    assign swap_pending = swapPending_q;
    assign busy         = (state_q == CLEAR);
    assign drop_cnt     = dropCnt_q;

endmodule

// File: tb/tb_buffer_ram_pingpong.sv
// Self-checking bench for buffer_ram_pingpong: clear, swap, range, drop and reset scenarios.
// Reads go through an expected-value queue filled when the address is driven.
module tb_buffer_ram_pingpong;

    localparam int AW = 15;
    localparam int DW = 12;
    localparam int IMA_SIZE = 19200;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_done;
    logic          rd_frame_start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          front_bank;
    logic          swap_pending;
    logic          busy;
    logic [7:0]    drop_cnt;

    int nVec = 0;
    int nErr = 0;
    logic [DW-1:0] expQ [$];

    buffer_ram_pingpong #(.AW(AW), .DW(DW), .IMA_SIZE(IMA_SIZE), .BG_COLOR(12'h000)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .rd_frame_start(rd_frame_start), .rd_addr(rd_addr),
        .rd_data(rd_data), .front_bank(front_bank), .swap_pending(swap_pending),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // All stimulus tasks start and finish on a falling edge.
    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic fd, input logic rfs);
        frame_done = fd;
        rd_frame_start = rfs;
        @(negedge clk);
        frame_done = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic writePix(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic readPix(input logic [AW-1:0] a, input logic [DW-1:0] e,
                           output logic [DW-1:0] got, output logic [DW-1:0] want);
        rd_addr = a;
        expQ.push_back(e);
        @(negedge clk);
        got = rd_data;
        want = expQ.pop_front();
    endtask

    task automatic waitClear(input bit poke, output int n);
        n = 0;
        while (busy === 1'b1 && n < 25000) begin
            if (poke && n == 500) begin
                wr_en = 1'b1; wr_addr = 3; wr_data = 12'h123; frame_done = 1'b1;
            end else begin
                wr_en = 1'b0; frame_done = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        wr_en = 1'b0; frame_done = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        if (rd_data !== 12'h000) begin nErr++; $display("[TB] FAIL rst_rd_data: got %h want 000", rd_data); end
        nVec++;
        if (front_bank !== 1'b0) begin nErr++; $display("[TB] FAIL rst_front: got %b want 0", front_bank); end
        nVec++;
        if (swap_pending !== 1'b0) begin nErr++; $display("[TB] FAIL rst_pending: got %b want 0", swap_pending); end
        nVec++;
        if (busy !== 1'b1) begin nErr++; $display("[TB] FAIL rst_busy: got %b want 1", busy); end
        nVec++;
        if (drop_cnt !== 8'd0) begin nErr++; $display("[TB] FAIL rst_drop: got %0d want 0", drop_cnt); end
        nVec++;
    endtask

    task automatic test_clear();
        int n;
        logic [DW-1:0] got, want;
        waitClear(1'b0, n);
        if (n != IMA_SIZE) begin nErr++; $display("[TB] FAIL clear_len: got %0d want %0d", n, IMA_SIZE); end
        nVec++;
        for (int b = 0; b < 2; b++) begin
            readPix(0, 12'h000, got, want);
            if (got !== want) begin nErr++; $display("[TB] FAIL clear_b%0d_a0: got %h want %h", b, got, want); end
            nVec++;
            readPix(IMA_SIZE - 1, 12'h000, got, want);
            if (got !== want) begin nErr++; $display("[TB] FAIL clear_b%0d_alast: got %h want %h", b, got, want); end
            nVec++;
            pulse(1'b1, 1'b0);
            pulse(1'b0, 1'b1);
            if (front_bank !== ~b[0]) begin nErr++; $display("[TB] FAIL clear_swap%0d: got %b want %b", b, front_bank, ~b[0]); end
            nVec++;
        end
    endtask

    task automatic test_write_swap();
        logic [DW-1:0] got, want;
        writePix(5, 12'hABC);
        pulse(1'b1, 1'b0);
        if (swap_pending !== 1'b1) begin nErr++; $display("[TB] FAIL ws_pending: got %b want 1", swap_pending); end
        nVec++;
        readPix(5, 12'h000, got, want);
        if (got !== want) begin nErr++; $display("[TB] FAIL ws_preswap: got %h want %h", got, want); end
        nVec++;
        // Read issued in the swap cycle still sees the old front bank.
        rd_frame_start = 1'b1;
        rd_addr = 5;
        expQ.push_back(12'h000);
        @(negedge clk);
        rd_frame_start = 1'b0;
        got = rd_data;
        want = expQ.pop_front();
        if (got !== want) begin nErr++; $display("[TB] FAIL ws_swapcycle: got %h want %h", got, want); end
        nVec++;
        if (front_bank !== 1'b1) begin nErr++; $display("[TB] FAIL ws_front: got %b want 1", front_bank); end
        nVec++;
        if (swap_pending !== 1'b0) begin nErr++; $display("[TB] FAIL ws_cleared: got %b want 0", swap_pending); end
        nVec++;
        readPix(5, 12'hABC, got, want);
        if (got !== want) begin nErr++; $display("[TB] FAIL ws_postswap: got %h want %h", got, want); end
        nVec++;
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] got, want;
        writePix(20000, 12'hFFF);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        if (front_bank !== 1'b0) begin nErr++; $display("[TB] FAIL oor_front: got %b want 0", front_bank); end
        nVec++;
        readPix(20000, 12'h000, got, want);
        if (got !== want) begin nErr++; $display("[TB] FAIL oor_read: got %h want %h", got, want); end
        nVec++;
        readPix(IMA_SIZE - 1, 12'h000, got, want);
        if (got !== want) begin nErr++; $display("[TB] FAIL oor_last: got %h want %h", got, want); end
        nVec++;
        readPix(5, 12'h000, got, want);
        if (got !== want) begin nErr++; $display("[TB] FAIL oor_bank0_a5: got %h want %h", got, want); end
        nVec++;
    endtask

    task automatic test_simultaneous();
        pulse(1'b1, 1'b1);
        if (front_bank !== 1'b0 || swap_pending !== 1'b1) begin
            nErr++; $display("[TB] FAIL sim_nopend: front/pend %b%b want 01", front_bank, swap_pending);
        end
        nVec++;
        pulse(1'b1, 1'b1);
        if (front_bank !== 1'b1 || swap_pending !== 1'b1) begin
            nErr++; $display("[TB] FAIL sim_pend: front/pend %b%b want 11", front_bank, swap_pending);
        end
        nVec++;
        if (drop_cnt !== 8'd0) begin nErr++; $display("[TB] FAIL sim_drop: got %0d want 0", drop_cnt); end
        nVec++;
        pulse(1'b0, 1'b1);
        if (front_bank !== 1'b0 || swap_pending !== 1'b0) begin
            nErr++; $display("[TB] FAIL sim_consume: front/pend %b%b want 00", front_bank, swap_pending);
        end
        nVec++;
    endtask

    task automatic test_drop();
        repeat (3) pulse(1'b1, 1'b0);
        if (drop_cnt !== 8'd2) begin nErr++; $display("[TB] FAIL drop_3: got %0d want 2", drop_cnt); end
        nVec++;
        if (swap_pending !== 1'b1) begin nErr++; $display("[TB] FAIL drop_pend: got %b want 1", swap_pending); end
        nVec++;
        repeat (297) pulse(1'b1, 1'b0);
        if (drop_cnt !== 8'd255) begin nErr++; $display("[TB] FAIL drop_sat: got %0d want 255", drop_cnt); end
        nVec++;
        if (front_bank !== 1'b0) begin nErr++; $display("[TB] FAIL drop_front: got %b want 0", front_bank); end
        nVec++;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic [DW-1:0] got, want;
        doReset();
        if (front_bank !== 1'b0 || swap_pending !== 1'b0 || drop_cnt !== 8'd0) begin
            nErr++; $display("[TB] FAIL mid_rst_state: front %b pend %b drop %0d want 0 0 0", front_bank, swap_pending, drop_cnt);
        end
        nVec++;
        repeat (1000) @(negedge clk);
        if (busy !== 1'b1) begin nErr++; $display("[TB] FAIL mid_busy: got %b want 1", busy); end
        nVec++;
        doReset();
        waitClear(1'b1, n);
        if (n != IMA_SIZE) begin nErr++; $display("[TB] FAIL mid_clear_len: got %0d want %0d", n, IMA_SIZE); end
        nVec++;
        if (swap_pending !== 1'b0) begin nErr++; $display("[TB] FAIL mid_fd_ignored: got %b want 0", swap_pending); end
        nVec++;
        readPix(3, 12'h000, got, want);
        if (got !== want) begin nErr++; $display("[TB] FAIL mid_b0_a3: got %h want %h", got, want); end
        nVec++;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        readPix(3, 12'h000, got, want);
        if (got !== want) begin nErr++; $display("[TB] FAIL mid_b1_a3: got %h want %h", got, want); end
        nVec++;
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frame_done = 1'b0; rd_frame_start = 1'b0; rd_addr = '0;
        @(negedge clk);
        test_reset();
        test_clear();
        test_write_swap();
        test_out_of_range();
        test_simultaneous();
        test_drop();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
